// File: rtl/axi_dw_downsizer_w_ctrl.sv
// W-channel controller for an AXI data-width downsizer: splits each wide W beat
// into narrow beats, tracking the byte address to pick the lane and find the wide-beat end.
module axi_dw_downsizer_w_ctrl #(
    parameter int unsigned SlvDataWidth = 64,
    parameter int unsigned MstDataWidth = 32,
    parameter int unsigned UserWidth    = 8,
    localparam int unsigned SlvBytes    = SlvDataWidth / 8,
    localparam int unsigned MstBytes    = MstDataWidth / 8,
    localparam int unsigned Ratio       = SlvBytes / MstBytes,
    localparam int unsigned OffW        = $clog2(SlvBytes),
    localparam int unsigned MstOffW     = $clog2(MstBytes),
    localparam int unsigned LaneW       = $clog2(Ratio)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [OffW-1:0]         cmd_addr_i,
    input  logic [2:0]              cmd_size_i,
    input  logic [7:0]              cmd_len_i,
    input  logic                    slv_w_valid_i,
    output logic                    slv_w_ready_o,
    input  logic [SlvDataWidth-1:0] slv_w_data_i,
    input  logic [SlvBytes-1:0]     slv_w_strb_i,
    input  logic [UserWidth-1:0]    slv_w_user_i,
    output logic                    mst_w_valid_o,
    input  logic                    mst_w_ready_i,
    output logic [MstDataWidth-1:0] mst_w_data_o,
    output logic [MstBytes-1:0]     mst_w_strb_o,
    output logic [UserWidth-1:0]    mst_w_user_o,
    output logic                    mst_w_last_o,
    output logic [LaneW-1:0]        lane_o
);

    typedef enum logic {IDLE, BURST} state_e;

    localparam logic [OffW:0] One       = 1;
    localparam logic [OffW:0] MstBytesW = (OffW+1)'(MstBytes);
    localparam logic [2:0]    MaxSize   = 3'(OffW);

    state_e          state_q;
    logic [OffW-1:0] addr_q;
    logic [2:0]      size_q;
    logic [7:0]      len_q;
    logic [7:0]      beat_cnt_q;

    logic [OffW-1:0] addr_d;
    logic [OffW:0]   size_bytes;
    logic [OffW:0]   size_m1;
    logic [OffW:0]   step;
    logic [OffW:0]   addr_sum;
    logic            end_of_wide;
    logic            burst;
    logic            mst_hs;
    logic [2:0]      cmd_size_clamped;

    // Narrow step never exceeds the narrow bus; the wide beat ends when the
    // next address is aligned to the original beat size.
    always_comb begin
        size_bytes  = One << size_q;
        size_m1     = size_bytes - One;
        step        = (size_bytes < MstBytesW) ? size_bytes : MstBytesW;
        addr_sum    = ({1'b0, addr_q} & ~(step - One)) + step;
        addr_d      = addr_sum[OffW-1:0];
        end_of_wide = ((addr_d & size_m1[OffW-1:0]) == '0);
    end

    assign cmd_size_clamped = (cmd_size_i > MaxSize) ? MaxSize : cmd_size_i;

    assign burst         = (state_q == BURST);
    assign cmd_ready_o   = (state_q == IDLE);
    assign mst_w_valid_o = burst & slv_w_valid_i;
    assign mst_hs        = mst_w_valid_o & mst_w_ready_i;
    assign slv_w_ready_o = burst & mst_w_ready_i & end_of_wide;
    assign mst_w_last_o  = burst & (beat_cnt_q == len_q) & end_of_wide;

    assign lane_o       = addr_q[OffW-1:MstOffW];
    assign mst_w_data_o = slv_w_data_i[lane_o*MstDataWidth +: MstDataWidth];
    assign mst_w_strb_o = slv_w_strb_i[lane_o*MstBytes +: MstBytes];
    assign mst_w_user_o = slv_w_user_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q     <= cmd_addr_i;
                        size_q     <= cmd_size_clamped;
                        len_q      <= cmd_len_i;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (mst_hs) begin
                        addr_q <= addr_d;
                        // Last beat exits before the counter could wrap on len=255.
                        if (mst_w_last_o) begin
                            state_q <= IDLE;
                        end else if (end_of_wide) begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dw_downsizer_w_ctrl.sv
// Directed bench for axi_dw_downsizer_w_ctrl with 64-bit wide and 32-bit narrow W buses.
module tb_axi_dw_downsizer_w_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_addr;
    logic [2:0]  cmd_size;
    logic [7:0]  cmd_len;
    logic        slv_w_valid;
    logic        slv_w_ready;
    logic [63:0] slv_w_data;
    logic [7:0]  slv_w_strb;
    logic [7:0]  slv_w_user;
    logic        mst_w_valid;
    logic        mst_w_ready;
    logic [31:0] mst_w_data;
    logic [3:0]  mst_w_strb;
    logic [7:0]  mst_w_user;
    logic        mst_w_last;
    logic [0:0]  lane;

    int n_cmp = 0;
    int n_err = 0;

    axi_dw_downsizer_w_ctrl #(
        .SlvDataWidth(64),
        .MstDataWidth(32),
        .UserWidth   (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_size_i   (cmd_size),
        .cmd_len_i    (cmd_len),
        .slv_w_valid_i(slv_w_valid),
        .slv_w_ready_o(slv_w_ready),
        .slv_w_data_i (slv_w_data),
        .slv_w_strb_i (slv_w_strb),
        .slv_w_user_i (slv_w_user),
        .mst_w_valid_o(mst_w_valid),
        .mst_w_ready_i(mst_w_ready),
        .mst_w_data_o (mst_w_data),
        .mst_w_strb_o (mst_w_strb),
        .mst_w_user_o (mst_w_user),
        .mst_w_last_o (mst_w_last),
        .lane_o       (lane)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input string tag, input logic [2:0] a, input logic [2:0] s,
                            input logic [7:0] l);
        cmd_addr  = a;
        cmd_size  = s;
        cmd_len   = l;
        cmd_valid = 1'b1;
        #1;
        check_eq({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [63:0] d, input logic exp_lane,
                                 input logic [3:0] exp_strb, input logic exp_srdy,
                                 input logic exp_last);
        check_eq({tag, ".valid"}, 64'(mst_w_valid), 64'd1);
        check_eq({tag, ".lane"},  64'(lane),        64'(exp_lane));
        check_eq({tag, ".data"},  64'(mst_w_data),  exp_lane ? 64'(d[63:32]) : 64'(d[31:0]));
        check_eq({tag, ".strb"},  64'(mst_w_strb),  64'(exp_strb));
        check_eq({tag, ".user"},  64'(mst_w_user),  64'(d[7:0]));
        check_eq({tag, ".sready"}, 64'(slv_w_ready), 64'(exp_srdy));
        check_eq({tag, ".last"},  64'(mst_w_last),  64'(exp_last));
    endtask

    // Stalls for 'stall' cycles with the narrow ready low, then completes the narrow beat.
    task automatic beat(input string tag, input int stall, input logic [63:0] d,
                        input logic [7:0] s, input logic exp_lane, input logic [3:0] exp_strb,
                        input logic exp_srdy, input logic exp_last);
        slv_w_valid = 1'b1;
        slv_w_data  = d;
        slv_w_strb  = s;
        slv_w_user  = d[7:0];
        mst_w_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            check_outputs($sformatf("%s.stall%0d", tag, i), d, exp_lane, exp_strb, 1'b0, exp_last);
            tick();
        end
        mst_w_ready = 1'b1;
        #1;
        check_outputs(tag, d, exp_lane, exp_strb, exp_srdy, exp_last);
        tick();
    endtask

    task automatic idle_check(input string tag);
        slv_w_valid = 1'b1;
        mst_w_ready = 1'b1;
        #1;
        check_eq({tag, ".cmd_ready"}, 64'(cmd_ready),   64'd1);
        check_eq({tag, ".valid"},     64'(mst_w_valid), 64'd0);
        check_eq({tag, ".sready"},    64'(slv_w_ready), 64'd0);
        check_eq({tag, ".last"},      64'(mst_w_last),  64'd0);
        tick();
        slv_w_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_size    = '0;
        cmd_len     = '0;
        slv_w_valid = 1'b0;
        slv_w_data  = '0;
        slv_w_strb  = '0;
        slv_w_user  = '0;
        mst_w_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst.lane", 64'(lane), 64'd0);
        idle_check("rst");

        send_cmd("t30", 3'd0, 3'd3, 8'd1);
        beat("t30.b1", 0, 64'hB1B1B1B1_A1A1A1A1, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0);
        beat("t30.b2", 0, 64'hB1B1B1B1_A1A1A1A1, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b0);
        beat("t30.b3", 0, 64'hB2B2B2B2_A2A2A2A2, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0);
        beat("t30.b4", 0, 64'hB2B2B2B2_A2A2A2A2, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b1);
        idle_check("t30.end");

        send_cmd("t31", 3'd4, 3'd2, 8'd2);
        beat("t31.b1", 0, 64'hC1C1C1C1_D1D1D1D1, 8'hF0, 1'b1, 4'hF, 1'b1, 1'b0);
        beat("t31.b2", 0, 64'hC2C2C2C2_D2D2D2D2, 8'h0F, 1'b0, 4'hF, 1'b1, 1'b0);
        beat("t31.b3", 0, 64'hC3C3C3C3_D3D3D3D3, 8'hF0, 1'b1, 4'hF, 1'b1, 1'b1);
        idle_check("t31.end");

        send_cmd("t32", 3'd4, 3'd3, 8'd1);
        beat("t32.b1", 0, 64'h11223344_55667788, 8'hF0, 1'b1, 4'hF, 1'b1, 1'b0);
        beat("t32.b2", 0, 64'h99AABBCC_DDEEFF01, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0);
        beat("t32.b3", 0, 64'h99AABBCC_DDEEFF01, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b1);
        idle_check("t32.end");

        send_cmd("t33", 3'd3, 3'd0, 8'd3);
        beat("t33.b1", 0, 64'h01020304_05060708, 8'h08, 1'b0, 4'b1000, 1'b1, 1'b0);
        beat("t33.b2", 0, 64'h11121314_15161718, 8'h10, 1'b1, 4'b0001, 1'b1, 1'b0);
        beat("t33.b3", 0, 64'h21222324_25262728, 8'h20, 1'b1, 4'b0010, 1'b1, 1'b0);
        beat("t33.b4", 0, 64'h31323334_35363738, 8'h40, 1'b1, 4'b0100, 1'b1, 1'b1);
        idle_check("t33.end");

        send_cmd("clamp", 3'd0, 3'd7, 8'd0);
        beat("clamp.b1", 0, 64'hE0E0E0E0_F0F0F0F0, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0);
        beat("clamp.b2", 0, 64'hE0E0E0E0_F0F0F0F0, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b1);
        idle_check("clamp.end");

        send_cmd("t34", 3'd0, 3'd3, 8'd0);
        beat("t34.b1", 0, 64'h5A5A5A5A_A5A5A5A5, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0);
        beat("t34.b2", 5, 64'h5A5A5A5A_A5A5A5A5, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b1);
        idle_check("t34.end");

        send_cmd("t35", 3'd0, 3'd3, 8'd3);
        beat("t35.b1", 0, 64'h77777777_66666666, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0);
        beat("t35.b2", 0, 64'h77777777_66666666, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b0);
        slv_w_valid = 1'b1;
        mst_w_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("t35.rst.cmd_ready", 64'(cmd_ready),   64'd1);
        check_eq("t35.rst.valid",     64'(mst_w_valid), 64'd0);
        check_eq("t35.rst.sready",    64'(slv_w_ready), 64'd0);
        check_eq("t35.rst.lane",      64'(lane),        64'd0);
        tick();
        slv_w_valid = 1'b0;
        send_cmd("t35.new", 3'd0, 3'd3, 8'd0);
        beat("t35.n1", 0, 64'h88888888_99999999, 8'hFF, 1'b0, 4'hF, 1'b0, 1'b0);
        beat("t35.n2", 0, 64'h88888888_99999999, 8'hFF, 1'b1, 4'hF, 1'b1, 1'b1);
        idle_check("t35.end");

        send_cmd("len255", 3'd0, 3'd2, 8'd255);
        for (int k = 0; k < 256; k++) begin
            beat($sformatf("len255.b%0d", k), 0, {32'hCAFE0000 | 32'(k), 32'hBEEF0000 | 32'(k)},
                 8'hFF, 1'(k % 2), 4'hF, 1'b1, (k == 255));
        end
        idle_check("len255.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_dw_downsizer_w_ctrl.md
AXI_DW_DOWNSIZER_W_CTRL -- requirements
Module: axi_dw_downsizer_w_ctrl

Interface
REQ-001 SlvDataWidth, default 64: wide (input) W data width in bits; SHALL be a power of two and greater than MstDataWidth.
REQ-002 MstDataWidth, default 32: narrow (output) W data width in bits; SHALL be a power of two, at least 8.
REQ-003 UserWidth, default 8: W user width in bits, passed through unchanged.
REQ-004 Derived: SlvBytes=SlvDataWidth/8, MstBytes=MstDataWidth/8, Ratio=SlvBytes/MstBytes, OffW=log2(SlvBytes).
REQ-005 clk_i  in  1  clock; all logic on the rising edge; one clock domain.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 cmd_valid_i / cmd_ready_o  in/out  1/1  write-burst command handshake.
REQ-008 cmd_addr_i  in  OffW  byte offset of the burst start address within the wide word.
REQ-009 cmd_size_i  in  3  AXI beat size (log2 bytes per beat); values above log2(SlvBytes) are clamped to log2(SlvBytes).
REQ-010 cmd_len_i  in  8  AXI len (number of wide beats minus one); burst type is INCR.
REQ-011 slv_w_valid_i / slv_w_ready_o  in/out  1/1  wide W handshake.
REQ-012 slv_w_data_i, slv_w_strb_i, slv_w_user_i  in  SlvDataWidth, SlvBytes, UserWidth  wide W payload.
REQ-013 mst_w_valid_o / mst_w_ready_i  out/in  1/1  narrow W handshake.
REQ-014 mst_w_data_o, mst_w_strb_o, mst_w_user_o, mst_w_last_o  out  MstDataWidth, MstBytes, UserWidth, 1  narrow W payload.
REQ-015 lane_o  out  log2(Ratio)  index of the narrow slice currently selected.

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 cmd_ready_o SHALL equal (state==IDLE); a cmd handshake SHALL load addr<=cmd_addr_i, size<=clamped cmd_size_i, len<=cmd_len_i, beat_cnt<=0, and move to BURST.
REQ-018 In BURST: mst_w_valid_o = slv_w_valid_i (combinational, zero latency); in IDLE: mst_w_valid_o=0, slv_w_ready_o=0.
REQ-019 lane_o SHALL equal addr[OffW-1:log2(MstBytes)]; mst_w_data_o/mst_w_strb_o SHALL be slice lane_o of slv_w_data_i/slv_w_strb_i; mst_w_user_o = slv_w_user_i.
REQ-020 step = min(2^size, MstBytes); on each narrow handshake addr_next = (addr aligned down to step) + step, modulo SlvBytes.
REQ-021 end_of_wide = (addr_next mod 2^size == 0); slv_w_ready_o SHALL be (state==BURST) & mst_w_ready_i & end_of_wide.
REQ-022 On a narrow handshake with end_of_wide, beat_cnt SHALL increment; otherwise it SHALL hold.
REQ-023 mst_w_last_o SHALL be (state==BURST) & (beat_cnt==len) & end_of_wide; slv_w_last_i is not used.
REQ-024 A narrow handshake with mst_w_last_o=1 SHALL return the FSM to IDLE; the next command is accepted no earlier than the following cycle (one-cycle bubble).
REQ-025 While mst_w_valid_o=1 and mst_w_ready_i=0, addr, beat_cnt, lane_o and all state SHALL hold.
REQ-026 A len=255 burst SHALL complete without beat_cnt overflow (8-bit counter compared before increment).

Reset
REQ-027 While rst_i=1 at a clock edge: state<=IDLE, addr<=0, size<=0, len<=0, beat_cnt<=0.
REQ-028 After reset: cmd_ready_o=1, mst_w_valid_o=0, slv_w_ready_o=0, mst_w_last_o=0, lane_o=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; no further narrow beats are issued for it.

Verification (SlvDataWidth=64, MstDataWidth=32)
REQ-030 size=3, addr=0, len=1, ready always high -> 4 narrow beats, lanes 0,1,0,1; slv_w_ready_o on beats 2 and 4; last on beat 4.
REQ-031 size=2, addr=4, len=2 -> 3 narrow beats, lanes 1,0,1; slv_w_ready_o on every beat; last on beat 3.
REQ-032 size=3, addr=4, len=1 (unaligned) -> 3 narrow beats, lanes 1,0,1; slv_w_ready_o on beats 1 and 3.
REQ-033 size=0, addr=3, len=3 -> 4 beats at addr 3,4,5,6, lanes 0,1,1,1; only strb bit 3 of the wide strb appears on the narrow strb at beat 1.
REQ-034 mst_w_ready_i held low 5 cycles mid-wide-beat -> mst_w_data_o, lane_o and mst_w_last_o stable; slv_w_ready_o=0 throughout.
REQ-035 rst_i pulsed after the 2nd narrow beat of a len=3, size=3 burst -> next cycle cmd_ready_o=1, mst_w_valid_o=0; a new command then runs from lane 0 normally.
